correlating_pht: RTL and testbench

//  (M,N) correlating branch-predictor pattern history table.
//  - Stores 2^(R+M) N-bit saturating counters; index = {GHR[M-1:0], PC[R-1:0]}.
//  - Owns the M-bit global history register (GHR) and the counter-update logic.
//  - Adds a registered predict port, an update port and a post-reset init sweep.
//  - Sits between fetch (predict) and branch resolution (update).

---
 rtl/cbp_pkg.sv | 22 ++
 rtl/cbp_ghr.sv | 30 +++
 rtl/correlating_pht.sv | 112 +++++++++++
 tb/tb_correlating_pht.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cbp_pkg.sv
// Shared types and helpers for the correlating branch predictor pattern history table.
package cbp_pkg;

  typedef enum logic {INIT, RUN} cbp_state_t;

  // Counters are handled as 32-bit values here so the helpers stay width-generic.
  function automatic logic [31:0] cnt_init(input int unsigned n);
    return (32'd1 << (n - 1)) - 32'd1;
  endfunction

  // Saturation is decided before the add/subtract, so neither end can wrap.
  function automatic logic [31:0] sat_next(input logic [31:0] cnt, input logic taken,
                                           input int unsigned n);
    logic [31:0] max_cnt;
    max_cnt = (32'd1 << n) - 32'd1;
    if (taken)
      return (cnt == max_cnt) ? cnt : cnt + 32'd1;
    else
      return (cnt == '0) ? cnt : cnt - 32'd1;
  endfunction

endpackage

// File: rtl/cbp_ghr.sv
// Global history register: non-speculative shift of resolved branch outcomes.
module cbp_ghr #(
  parameter int unsigned M = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         shift_en,
  input  logic         bit_in,
  output logic [M-1:0] ghr
);

  generate
    if (M == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          ghr <= '0;
        else if (shift_en)
          ghr <= bit_in;
      end
    end else begin : g_shift
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          ghr <= '0;
        else if (shift_en)
          ghr <= {ghr[M-2:0], bit_in};
      end
    end
  endgenerate

endmodule

// File: rtl/correlating_pht.sv
// (M,N) correlating pattern history table with GHR, registered predict port,
// saturating update port and a post-reset initialisation sweep.
module correlating_pht
  import cbp_pkg::*;
#(
  parameter int unsigned M = 2,
  parameter int unsigned N = 2,
  parameter int unsigned R = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         ready,
  input  logic         pred_req,
  input  logic [R-1:0] pred_pc,
  output logic         pred_vld,
  output logic         pred_taken,
  output logic [N-1:0] pred_cnt,
  output logic [M-1:0] pred_ghr,
  input  logic         upd_vld,
  input  logic [R-1:0] upd_pc,
  input  logic [M-1:0] upd_ghr,
  input  logic         upd_taken
);

  localparam int unsigned IW = R + M;
  localparam int unsigned DEPTH = 1 << IW;
  localparam logic [N-1:0] CNT_INIT = N'(cnt_init(N));

  cbp_state_t state, state_next;
  logic [IW-1:0] init_ptr;
  logic [N-1:0]  cnt_mem [DEPTH];
  logic [M-1:0]  ghr;

  logic          pred_fire, upd_fire;
  logic [IW-1:0] pidx, uidx, waddr;
  logic [N-1:0]  upd_next, wdata, pred_val;
  logic          we;

  assign ready     = (state == RUN);
  assign pred_fire = pred_req & ready;
  assign upd_fire  = upd_vld & ready;
  assign pidx      = {ghr, pred_pc};
  assign uidx      = {upd_ghr, upd_pc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      init_ptr <= '0;
    end else begin
      state <= state_next;
      if (state == INIT)
        init_ptr <= init_ptr + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    if (state == INIT && (&init_ptr))
      state_next = RUN;
  end

  always_comb begin
    upd_next = N'(sat_next(32'(cnt_mem[uidx]), upd_taken, N));
    we       = 1'b0;
    waddr    = uidx;
    wdata    = upd_next;
    if (state == INIT) begin
      we    = 1'b1;
      waddr = init_ptr;
      wdata = CNT_INIT;
    end else if (upd_fire) begin
      we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we)
      cnt_mem[waddr] <= wdata;
  end

  // A same-cycle update to the predicted entry is forwarded so the prediction sees it.
  always_comb begin
    pred_val = cnt_mem[pidx];
    if (upd_fire && (uidx == pidx))
      pred_val = upd_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_vld   <= 1'b0;
      pred_taken <= 1'b0;
      pred_cnt   <= '0;
      pred_ghr   <= '0;
    end else begin
      pred_vld <= pred_fire;
      if (pred_fire) begin
        pred_cnt   <= pred_val;
        pred_taken <= pred_val[N-1];
        pred_ghr   <= ghr;
      end
    end
  end

  cbp_ghr #(.M(M)) u_ghr (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (upd_fire),
    .bit_in   (upd_taken),
    .ghr      (ghr)
  );

endmodule

// File: tb/tb_correlating_pht.sv
// Directed-vector bench for correlating_pht at M=2 N=2 R=8.
module tb_correlating_pht;

  logic       clk;
  logic       rst_n;
  logic       ready;
  logic       pred_req;
  logic [7:0] pred_pc;
  logic       pred_vld;
  logic       pred_taken;
  logic [1:0] pred_cnt;
  logic [1:0] pred_ghr;
  logic       upd_vld;
  logic [7:0] upd_pc;
  logic [1:0] upd_ghr;
  logic       upd_taken;

  int n_checks = 0;
  int n_fails  = 0;

  correlating_pht #(.M(2), .N(2), .R(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ready      (ready),
    .pred_req   (pred_req),
    .pred_pc    (pred_pc),
    .pred_vld   (pred_vld),
    .pred_taken (pred_taken),
    .pred_cnt   (pred_cnt),
    .pred_ghr   (pred_ghr),
    .upd_vld    (upd_vld),
    .upd_pc     (upd_pc),
    .upd_ghr    (upd_ghr),
    .upd_taken  (upd_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of requests, then sample #1 after the edge.
  task automatic run_cycle(input logic preq, input logic [7:0] ppc, input logic uvld,
                           input logic [7:0] upc, input logic [1:0] ughr, input logic utk);
    pred_req  = preq;
    pred_pc   = ppc;
    upd_vld   = uvld;
    upd_pc    = upc;
    upd_ghr   = ughr;
    upd_taken = utk;
    @(posedge clk);
    #1;
    pred_req = 1'b0;
    upd_vld  = 1'b0;
  endtask

  task automatic predict(input string tag, input logic [7:0] pc, input logic [1:0] exp_cnt,
                         input logic [1:0] exp_ghr);
    run_cycle(1'b1, pc, 1'b0, 8'h00, 2'b00, 1'b0);
    check_eq({tag, "_vld"}, 32'(pred_vld), 32'd1);
    check_eq({tag, "_cnt"}, 32'(pred_cnt), 32'(exp_cnt));
    check_eq({tag, "_taken"}, 32'(pred_taken), 32'(exp_cnt[1]));
    check_eq({tag, "_ghr"}, 32'(pred_ghr), 32'(exp_ghr));
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (!ready && cycles < 2000) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int vld_seen;

    rst_n = 1'b1;
    pred_req = 1'b0; pred_pc = '0;
    upd_vld = 1'b0; upd_pc = '0; upd_ghr = '0; upd_taken = 1'b0;

    // 1: reset values, sweep length, first prediction
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_ready", 32'(ready), 32'd0);
    check_eq("rst_pred_vld", 32'(pred_vld), 32'd0);
    check_eq("rst_pred_taken", 32'(pred_taken), 32'd0);
    check_eq("rst_pred_cnt", 32'(pred_cnt), 32'd0);
    check_eq("rst_pred_ghr", 32'(pred_ghr), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_ready(cyc);
    check_eq("sweep_len", 32'(cyc), 32'd1024);
    predict("t1_pc00", 8'h00, 2'b01, 2'b00);
    run_cycle(1'b0, 8'h00, 1'b0, 8'h00, 2'b00, 1'b0);
    check_eq("t1_vld_drop", 32'(pred_vld), 32'd0);
    check_eq("t1_cnt_hold", 32'(pred_cnt), 32'd1);

    // 2: back-to-back saturating increments, then decrements to the floor
    repeat (4) run_cycle(1'b0, 8'h00, 1'b1, 8'h12, 2'b00, 1'b1);
    repeat (4) run_cycle(1'b0, 8'h00, 1'b1, 8'h34, 2'b00, 1'b0);
    predict("t2_pc12", 8'h12, 2'b11, 2'b00);
    predict("t2_pc34", 8'h34, 2'b00, 2'b00);

    // 3: history selects the row; entry 0x205 is driven to 00 while 0x005 is 10
    run_cycle(1'b0, 8'h00, 1'b1, 8'h05, 2'b00, 1'b1);
    run_cycle(1'b0, 8'h00, 1'b1, 8'h05, 2'b10, 1'b0);
    predict("t3_pc05", 8'h05, 2'b00, 2'b10);

    // 4: same-cycle predict and update of entry 0x207 (01 -> 10 forwarded)
    run_cycle(1'b1, 8'h07, 1'b1, 8'h07, 2'b10, 1'b1);
    check_eq("t4_vld", 32'(pred_vld), 32'd1);
    check_eq("t4_cnt", 32'(pred_cnt), 32'd2);
    check_eq("t4_taken", 32'(pred_taken), 32'd1);
    check_eq("t4_ghr", 32'(pred_ghr), 32'd2);

    // 5: requests held during the whole sweep are ignored
    pred_req = 1'b1; pred_pc = 8'h12;
    upd_vld = 1'b1; upd_pc = 8'h34; upd_ghr = 2'b00; upd_taken = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    vld_seen = 0;
    while (!ready && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (pred_vld) vld_seen++;
    end
    pred_req = 1'b0;
    upd_vld  = 1'b0;
    check_eq("t5_sweep_len", 32'(cyc), 32'd1024);
    check_eq("t5_vld_in_init", 32'(vld_seen), 32'd0);
    predict("t5_pc12", 8'h12, 2'b01, 2'b00);
    predict("t5_pc34", 8'h34, 2'b01, 2'b00);
    predict("t5_pc07", 8'h07, 2'b01, 2'b00);

    // 6: forwarded and non-forwarded same-cycle pairs, then async reset and mid-sweep restart
    run_cycle(1'b1, 8'h10, 1'b1, 8'h10, 2'b00, 1'b1);
    check_eq("t6_fwd_cnt", 32'(pred_cnt), 32'd2);
    check_eq("t6_fwd_ghr", 32'(pred_ghr), 32'd0);
    run_cycle(1'b1, 8'h11, 1'b1, 8'h10, 2'b00, 1'b1);
    check_eq("t6_nofwd_cnt", 32'(pred_cnt), 32'd1);
    check_eq("t6_nofwd_ghr", 32'(pred_ghr), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check_eq("t6_async_ready", 32'(ready), 32'd0);
    check_eq("t6_async_vld", 32'(pred_vld), 32'd0);
    check_eq("t6_async_cnt", 32'(pred_cnt), 32'd0);
    check_eq("t6_async_ghr", 32'(pred_ghr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (500) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(cyc);
    check_eq("t6_restart_len", 32'(cyc), 32'd1024);
    predict("t6_pc10", 8'h10, 2'b01, 2'b00);
    predict("t6_pc00", 8'h00, 2'b01, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
